// File: rtl/msdap_p2s_tx.sv
// -----------------------------------------------------------------------------
// msdap_p2s_tx
//   Output-side parallel-to-serial transmitter for the MSDAP datapath.
//   Control strobes p2s_load to capture the left/right filter results; the
//   next frame strobe shifts both words out MSB-first on out_l/out_r, with
//   out_ready high on every cycle that carries a valid bit. A second holding
//   buffer lets the ALU deliver the next result while the current word is
//   still shifting.
//
//   Parameters
//     DATA_W  bits per channel word (bits shifted per frame)
//     CNT_W   bit-counter width, 2**CNT_W must exceed DATA_W
//
//   Ports
//     clk        system clock, rising edge
//     reset_n    asynchronous active-low reset
//     p2s_clear  synchronous clear from Control (beats frame and p2s_load)
//     p2s_load   one-cycle strobe, capture data_l/data_r
//     data_l/r   left/right result words from the ALU
//     frame      one-cycle output frame strobe
//     out_l/r    serial data bits, 0 whenever out_ready is 0
//     out_ready  high on each cycle carrying a valid bit
//     busy       high while a word is armed or shifting
//     done       one-cycle pulse after the last bit has been shifted
//     overrun    one-cycle pulse when an unsent word is overwritten
// -----------------------------------------------------------------------------
module msdap_p2s_tx #(
  parameter int DATA_W = 40,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p2s_clear,
  input  logic              p2s_load,
  input  logic [DATA_W-1:0] data_l,
  input  logic [DATA_W-1:0] data_r,
  input  logic              frame,
  output logic              out_l,
  output logic              out_r,
  output logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] shift_l_q, shift_r_q;
  logic [DATA_W-1:0] hold_l_q,  hold_r_q;
  logic              pending_q;
  logic [CNT_W-1:0]  cnt_q;

  // Next values of the registered outputs.
  logic out_l_d, out_r_d, out_ready_d, busy_d, done_d, overrun_d;

  // cnt_q counts the bits still to come after the one currently on the wire,
  // so cnt_q == 0 in SHIFT means the last bit is being presented this cycle.
  logic last_bit;
  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (p2s_clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (p2s_load) state_d = ARMED;
        ARMED:   if (frame)    state_d = SHIFT;
        SHIFT:   if (last_bit) state_d = (pending_q || p2s_load) ? ARMED : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (values registered on the next edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_ready_d = 1'b0;
    out_l_d     = 1'b0;
    out_r_d     = 1'b0;
    done_d      = 1'b0;
    overrun_d   = 1'b0;
    busy_d      = (state_d != IDLE);
    if (!p2s_clear) begin
      unique case (state_q)
        ARMED: begin
          if (frame) begin
            out_ready_d = 1'b1;
            out_l_d     = shift_l_q[DATA_W-1];
            out_r_d     = shift_r_q[DATA_W-1];
          end else if (p2s_load) begin
            // The armed word was never sent and is being replaced.
            overrun_d = 1'b1;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            done_d = 1'b1;
          end else begin
            out_ready_d = 1'b1;
            out_l_d     = shift_l_q[DATA_W-1];
            out_r_d     = shift_r_q[DATA_W-1];
          end
          if (p2s_load && pending_q) overrun_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift registers, holding buffer, bit counter
  // ---------------------------------------------------------------------------
  // NOTE: the word registers are ordinary flops (not a RAM), so they are
  // reset; this guarantees zeros on the wire and no stale pending word after
  // reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_l_q <= '0;
      shift_r_q <= '0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else if (p2s_clear) begin
      shift_l_q <= '0;
      shift_r_q <= '0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (p2s_load) begin
            shift_l_q <= data_l;
            shift_r_q <= data_r;
          end
        end
        ARMED: begin
          if (frame) begin
            // MSB goes to the output register this edge; pre-shift here.
            shift_l_q <= {shift_l_q[DATA_W-2:0], 1'b0};
            shift_r_q <= {shift_r_q[DATA_W-2:0], 1'b0};
            cnt_q     <= CNT_W'(DATA_W - 1);
            if (p2s_load) begin
              // Frame wins: the armed word goes out, the new one waits.
              hold_l_q  <= data_l;
              hold_r_q  <= data_r;
              pending_q <= 1'b1;
            end
          end else if (p2s_load) begin
            shift_l_q <= data_l;
            shift_r_q <= data_r;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            // A load arriving on the last bit is newer than the held word.
            if (p2s_load) begin
              shift_l_q <= data_l;
              shift_r_q <= data_r;
            end else if (pending_q) begin
              shift_l_q <= hold_l_q;
              shift_r_q <= hold_r_q;
            end
            pending_q <= 1'b0;
          end else begin
            shift_l_q <= {shift_l_q[DATA_W-2:0], 1'b0};
            shift_r_q <= {shift_r_q[DATA_W-2:0], 1'b0};
            cnt_q     <= cnt_q - CNT_W'(1);
            if (p2s_load) begin
              hold_l_q  <= data_l;
              hold_r_q  <= data_r;
              pending_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_l     <= 1'b0;
      out_r     <= 1'b0;
      out_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_l     <= out_l_d;
      out_r     <= out_r_d;
      out_ready <= out_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: doc/msdap_p2s_tx.md
Name: msdap_p2s_tx

Overview:
- Output-side parallel-to-serial transmitter for the MSDAP datapath; the transmit counterpart of the input serial-to-parallel receiver.
- Captures the left and right filter results when Control asserts p2s_load.
- On the next frame pulse, shifts both words out MSB-first on out_l/out_r with out_ready qualifying every bit.
- Double-buffered, so the ALU can deliver the next result while the current one is still shifting.

Parameters:
DATA_W, 40, width of each channel's output word (bits shifted per frame)
CNT_W, 6, width of the bit counter; must satisfy 2**CNT_W > DATA_W

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
p2s_clear  input  1  synchronous clear from Control (sleep/clear states)
p2s_load  input  1  one-cycle strobe: capture data_l/data_r
data_l  input  DATA_W  left-channel result from ALU
data_r  input  DATA_W  right-channel result from ALU
frame  input  1  output frame strobe, one cycle wide
out_l  output  1  left serial data bit
out_r  output  1  right serial data bit
out_ready  output  1  high on each cycle carrying a valid output bit
busy  output  1  high in ARMED or SHIFT
done  output  1  one-cycle pulse after last bit shifted
overrun  output  1  one-cycle pulse when a pending word is overwritten unsent

Behaviour:
- Reset (reset_n=0, async): state=IDLE; shift regs, holding regs, counter and pending cleared; all outputs 0.
- Registers: shift_l/shift_r (active word), hold_l/hold_r plus pending flag (second buffer), bit counter cnt.
- IDLE:
  - p2s_load copies data into shift_l/shift_r, then ARMED.
  - frame ignored.
- ARMED:
  - frame at cycle t: SHIFT; cnt=DATA_W-1.
  - Cycle t+1: out_ready=1 with out_l=shift_l[DATA_W-1], out_r=shift_r[DATA_W-1].
  - p2s_load without frame overwrites shift_l/shift_r and pulses overrun next cycle.
  - frame and p2s_load in the same cycle: frame wins; old word shifts; new word goes to hold regs with pending=1; no overrun.
- SHIFT:
  - Each cycle: out_ready=1, out_l/out_r = current MSB, shift regs shift left by 1 (zero fill), cnt decrements.
  - DATA_W consecutive out_ready cycles (t+1 .. t+DATA_W), no gaps.
  - frame ignored.
  - p2s_load: hold regs <= data, pending=1; if pending was already 1, pulse overrun and overwrite.
  - On the last bit (cnt==0): next cycle done=1 and out_ready=0.
    - pending=1: move hold to shift, pending=0, go to ARMED. A p2s_load in that same last-bit cycle counts as the pending word.
    - pending=0: go to IDLE.
- out_l/out_r are 0 whenever out_ready=0.
- busy=1 in ARMED and SHIFT.
- p2s_clear (any state): next cycle state=IDLE; all registers and pending cleared; outputs 0. No done or overrun pulse is produced.
  - Priority: reset_n > p2s_clear > frame > p2s_load.
- Reset or clear mid-SHIFT truncates the word. No partial done.
- All outputs are registered.

Test Plan:
- Reset then load data_l=40'h80_0000_0001, data_r=40'h00_0000_0000, frame -> cycle after frame: out_ready=1, out_l=1, out_r=0; out_l=0 for 38 cycles, then 1 on the 40th; done pulse in cycle 41; busy=0 after.
- frame in IDLE with no prior load -> out_ready stays 0, busy=0, no done.
- Load A=40'hFF00_0000_00, frame, load B=40'h0F_0000_0000 at bit 10 -> A fully sent (40 cycles), done, state ARMED; next frame sends B MSB-first.
- Two loads during one SHIFT (B at bit 5, C at bit 20) -> overrun pulses once at bit 21; after done the next frame transmits C.
- p2s_clear asserted at bit 15 of a transfer -> next cycle out_ready=0, busy=0, no done pulse; a later frame without a load produces no output.
- reset_n pulsed low mid-SHIFT (asynchronous, between clock edges) -> outputs 0 immediately; after release the block is in IDLE with pending=0.
